// File: rtl/game_flow_ctrl_if.sv
// Control/status bundle between the game sequencer and its surrounding blocks.
// The sequencer takes the slave view; the driver of the inputs takes the master view.
interface game_flow_ctrl_if;
   logic       enter;
   logic       frame_tick;
   logic       ep_boom;
   logic       boss_dead;
   logic [3:0] health;
   logic [1:0] state;
   logic       play_en;
   logic       end_en;
   logic       win;
   logic       boss_spawn;
   logic       game_rst_n;
   logic [9:0] score;

   modport master (
      output enter, frame_tick, ep_boom, boss_dead, health,
      input  state, play_en, end_en, win, boss_spawn, game_rst_n, score
   );

   modport slave (
      input  enter, frame_tick, ep_boom, boss_dead, health,
      output state, play_en, end_en, win, boss_spawn, game_rst_n, score
   );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game phase sequencer: start screen, play, boss phase, game over.
// Counts kills into a saturating score and issues the one-shot boss spawn.
module game_flow_ctrl #(
   parameter int unsigned BOSS_SCORE  = 10,
   parameter int unsigned BOSS_BONUS  = 50,
   parameter int unsigned HOLD_FRAMES = 120
) (
   input  logic            clk,
   input  logic            rst,
   game_flow_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      BOSS = 2'b10,
      OVER = 2'b11
   } state_t;

   localparam logic [10:0] SCORE_MAX = 11'd999;
   localparam logic [10:0] BOSS_AT   = 11'(BOSS_SCORE);
   localparam logic [10:0] BONUS     = 11'(BOSS_BONUS);
   localparam logic [7:0]  HOLD_MAX  = 8'(HOLD_FRAMES);

   state_t     state_q, state_d;
   logic       enter_q, boom_q, dead_q;
   logic       guard_q, guard_d;
   logic [7:0] hold_q, hold_d;
   logic [9:0] score_q, score_d;
   logic       win_q, win_d;
   logic       spawn_q, spawn_d;
   logic       play_en_q, end_en_q, game_rst_n_q;
   logic       enter_rise, boom_rise, dead_rise, died;
   logic [9:0] score_kill;

   function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [10:0] b);
      logic [10:0] s;
      s = {1'b0, a} + b;
      return (s > SCORE_MAX) ? 10'd999 : s[9:0];
   endfunction

   assign enter_rise = bus.enter & ~enter_q;
   assign boom_rise  = bus.ep_boom & ~boom_q;
   assign dead_rise  = bus.boss_dead & ~dead_q;
   // Zero health only counts once the health judge has had a cycle out of reset.
   assign died       = guard_q && (bus.health == '0);
   assign score_kill = boom_rise ? sat_add(score_q, 11'd1) : score_q;

   always_comb begin
      state_d = state_q;
      guard_d = 1'b1;
      hold_d  = hold_q;
      score_d = score_q;
      win_d   = win_q;
      spawn_d = 1'b0;
      case (state_q)
         IDLE: begin
            score_d = '0;
            win_d   = 1'b0;
            if (enter_rise) begin
               state_d = PLAY;
               guard_d = 1'b0;
            end
         end
         PLAY: begin
            score_d = score_kill;
            if (died) begin
               state_d = OVER;
               win_d   = 1'b0;
               hold_d  = '0;
            end else if (boom_rise && ({1'b0, score_kill} >= BOSS_AT)) begin
               state_d = BOSS;
               spawn_d = 1'b1;
            end
         end
         BOSS: begin
            score_d = score_kill;
            if (died) begin
               state_d = OVER;
               win_d   = 1'b0;
               hold_d  = '0;
            end else if (dead_rise) begin
               state_d = OVER;
               win_d   = 1'b1;
               hold_d  = '0;
               score_d = sat_add(score_kill, BONUS);
            end
         end
         OVER: begin
            if (bus.frame_tick && (hold_q != HOLD_MAX)) hold_d = hold_q + 8'd1;
            if (enter_rise && (hold_q == HOLD_MAX)) begin
               state_d = IDLE;
               score_d = '0;
               win_d   = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         enter_q      <= 1'b0;
         boom_q       <= 1'b0;
         dead_q       <= 1'b0;
         guard_q      <= 1'b0;
         hold_q       <= '0;
         score_q      <= '0;
         win_q        <= 1'b0;
         spawn_q      <= 1'b0;
         play_en_q    <= 1'b0;
         end_en_q     <= 1'b0;
         game_rst_n_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         enter_q      <= bus.enter;
         boom_q       <= bus.ep_boom;
         dead_q       <= bus.boss_dead;
         guard_q      <= guard_d;
         hold_q       <= hold_d;
         score_q      <= score_d;
         win_q        <= win_d;
         spawn_q      <= spawn_d;
         play_en_q    <= (state_d == PLAY) || (state_d == BOSS);
         end_en_q     <= (state_d == OVER);
         game_rst_n_q <= (state_d != IDLE);
      end
   end

   assign bus.state      = state_q;
   assign bus.play_en    = play_en_q;
   assign bus.end_en     = end_en_q;
   assign bus.win        = win_q;
   assign bus.boss_spawn = spawn_q;
   assign bus.game_rst_n = game_rst_n_q;
   assign bus.score      = score_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: vector table through a scoreboard queue on the main
// instance, plus a saturation run and async reset checks on a second instance.
module tb_game_flow_ctrl;
   localparam int S_IDLE = 0;
   localparam int S_PLAY = 1;
   localparam int S_BOSS = 2;
   localparam int S_OVER = 3;

   typedef struct {
      logic       enter;
      logic       tick;
      logic       boom;
      logic       dead;
      logic [3:0] health;
      logic [1:0] st;
      logic       win;
      logic       spawn;
      logic [9:0] score;
   } vec_t;

   logic clk;
   logic rst;
   int unsigned checks = 0;
   int unsigned errors = 0;
   vec_t vecs[$];
   vec_t exp_q[$];

   game_flow_ctrl_if a_if ();
   game_flow_ctrl_if b_if ();

   game_flow_ctrl #(.BOSS_SCORE(10), .BOSS_BONUS(50), .HOLD_FRAMES(4)) dut (
      .clk(clk), .rst(rst), .bus(a_if.slave)
   );

   game_flow_ctrl #(.BOSS_SCORE(999), .BOSS_BONUS(50), .HOLD_FRAMES(4)) dut_sat (
      .clk(clk), .rst(rst), .bus(b_if.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s #%0d got %0d want %0d", name, idx, act, exp);
      end
   endtask

   task automatic chk_rst(input string tag, input logic [1:0] st, input logic pe, input logic ee,
                          input logic w, input logic sp, input logic gr, input logic [9:0] sc);
      chk({tag, "_state"}, 0, 32'(st), 32'd0);
      chk({tag, "_play_en"}, 0, 32'(pe), 32'd0);
      chk({tag, "_end_en"}, 0, 32'(ee), 32'd0);
      chk({tag, "_win"}, 0, 32'(w), 32'd0);
      chk({tag, "_spawn"}, 0, 32'(sp), 32'd0);
      chk({tag, "_game_rst_n"}, 0, 32'(gr), 32'd0);
      chk({tag, "_score"}, 0, 32'(sc), 32'd0);
   endtask

   function automatic void add(input int en, input int tk, input int bm, input int dd, input int h,
                               input int st, input int w, input int sp, input int sc);
      vec_t v;
      v.enter  = en[0];
      v.tick   = tk[0];
      v.boom   = bm[0];
      v.dead   = dd[0];
      v.health = h[3:0];
      v.st     = st[1:0];
      v.win    = w[0];
      v.spawn  = sp[0];
      v.score  = sc[9:0];
      vecs.push_back(v);
   endfunction

   task automatic stepb(input logic en, input logic bm);
      @(negedge clk);
      b_if.enter   = en;
      b_if.ep_boom = bm;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t e;
      // Start, 10 kills into the boss phase, held kill counts once, win with bonus
      for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 5, S_PLAY, 0, 0, 0);
      add(0, 0, 0, 0, 5, S_PLAY, 0, 0, 0);
      for (int i = 1; i <= 9; i++) begin
         add(0, 0, 1, 0, 5, S_PLAY, 0, 0, i);
         add(0, 0, 0, 0, 5, S_PLAY, 0, 0, i);
      end
      add(0, 0, 1, 0, 5, S_BOSS, 0, 1, 10);
      add(0, 0, 0, 0, 5, S_BOSS, 0, 0, 10);
      for (int i = 0; i < 50; i++) add(0, 0, 1, 0, 5, S_BOSS, 0, 0, 11);
      add(0, 0, 0, 0, 5, S_BOSS, 0, 0, 11);
      add(0, 0, 1, 0, 5, S_BOSS, 0, 0, 12);
      add(0, 0, 0, 0, 5, S_BOSS, 0, 0, 12);
      add(0, 0, 0, 1, 5, S_OVER, 1, 0, 62);
      add(0, 0, 0, 0, 5, S_OVER, 1, 0, 62);
      // Hold period: early Enter and Enter held over the last tick are both ignored
      for (int i = 0; i < 3; i++) begin
         add(0, 1, 0, 0, 5, S_OVER, 1, 0, 62);
         add(0, 0, 0, 0, 5, S_OVER, 1, 0, 62);
      end
      add(1, 0, 0, 0, 5, S_OVER, 1, 0, 62);
      add(0, 0, 0, 0, 5, S_OVER, 1, 0, 62);
      add(1, 1, 0, 0, 5, S_OVER, 1, 0, 62);
      for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 5, S_OVER, 1, 0, 62);
      add(0, 0, 0, 0, 5, S_OVER, 1, 0, 62);
      add(1, 0, 0, 0, 5, S_IDLE, 0, 0, 0);
      add(0, 0, 0, 0, 5, S_IDLE, 0, 0, 0);
      // Boss phase again: death and boss kill in the same cycle, death wins
      add(1, 0, 0, 0, 5, S_PLAY, 0, 0, 0);
      add(0, 0, 0, 0, 5, S_PLAY, 0, 0, 0);
      for (int i = 1; i <= 9; i++) begin
         add(0, 0, 1, 0, 5, S_PLAY, 0, 0, i);
         add(0, 0, 0, 0, 5, S_PLAY, 0, 0, i);
      end
      add(0, 0, 1, 0, 5, S_BOSS, 0, 1, 10);
      add(0, 0, 0, 0, 5, S_BOSS, 0, 0, 10);
      add(0, 0, 0, 1, 0, S_OVER, 0, 0, 10);
      add(0, 0, 0, 0, 5, S_OVER, 0, 0, 10);
      for (int i = 0; i < 4; i++) begin
         add(0, 1, 0, 0, 5, S_OVER, 0, 0, 10);
         add(0, 0, 0, 0, 5, S_OVER, 0, 0, 10);
      end
      add(1, 0, 0, 0, 5, S_IDLE, 0, 0, 0);
      add(0, 0, 0, 0, 5, S_IDLE, 0, 0, 0);
      // Guard: zero health ignored one cycle after entry, acted on the next
      add(1, 0, 0, 0, 0, S_PLAY, 0, 0, 0);
      add(0, 0, 0, 0, 0, S_PLAY, 0, 0, 0);
      add(0, 0, 1, 0, 0, S_OVER, 0, 0, 1);
      add(0, 0, 0, 0, 5, S_OVER, 0, 0, 1);

      a_if.enter = 1'b0; a_if.frame_tick = 1'b0; a_if.ep_boom = 1'b0;
      a_if.boss_dead = 1'b0; a_if.health = 4'd5;
      b_if.enter = 1'b0; b_if.frame_tick = 1'b0; b_if.ep_boom = 1'b0;
      b_if.boss_dead = 1'b0; b_if.health = 4'd5;
      rst = 1'b1;
      #1 rst = 1'b0;
      #2;
      chk_rst("por_a", a_if.state, a_if.play_en, a_if.end_en, a_if.win, a_if.boss_spawn,
              a_if.game_rst_n, a_if.score);
      chk_rst("por_b", b_if.state, b_if.play_en, b_if.end_en, b_if.win, b_if.boss_spawn,
              b_if.game_rst_n, b_if.score);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         a_if.enter      = vecs[i].enter;
         a_if.frame_tick = vecs[i].tick;
         a_if.ep_boom    = vecs[i].boom;
         a_if.boss_dead  = vecs[i].dead;
         a_if.health     = vecs[i].health;
         exp_q.push_back(vecs[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         chk("state", i, 32'(a_if.state), 32'(e.st));
         chk("play_en", i, 32'(a_if.play_en), 32'(e.st == 2'd1 || e.st == 2'd2));
         chk("end_en", i, 32'(a_if.end_en), 32'(e.st == 2'd3));
         chk("game_rst_n", i, 32'(a_if.game_rst_n), 32'(e.st != 2'd0));
         chk("win", i, 32'(a_if.win), 32'(e.win));
         chk("boss_spawn", i, 32'(a_if.boss_spawn), 32'(e.spawn));
         chk("score", i, 32'(a_if.score), 32'(e.score));
      end

      // Saturation: boss entry at 999, further kill stays at 999
      stepb(1'b1, 1'b0);
      chk("sat_start", 0, 32'(b_if.state), 32'(S_PLAY));
      stepb(1'b0, 1'b0);
      for (int k = 1; k <= 1000; k++) begin
         stepb(1'b0, 1'b1);
         if (k == 998) begin
            chk("sat_998_score", k, 32'(b_if.score), 32'd998);
            chk("sat_998_state", k, 32'(b_if.state), 32'(S_PLAY));
         end
         if (k == 999) begin
            chk("sat_999_state", k, 32'(b_if.state), 32'(S_BOSS));
            chk("sat_999_spawn", k, 32'(b_if.boss_spawn), 32'd1);
            chk("sat_999_score", k, 32'(b_if.score), 32'd999);
         end
         if (k == 1000) begin
            chk("sat_1000_state", k, 32'(b_if.state), 32'(S_BOSS));
            chk("sat_1000_spawn", k, 32'(b_if.boss_spawn), 32'd0);
            chk("sat_1000_score", k, 32'(b_if.score), 32'd999);
         end
         stepb(1'b0, 1'b0);
         if (k == 999) chk("sat_spawn_drop", k, 32'(b_if.boss_spawn), 32'd0);
      end

      // Asynchronous reset between clock edges: main in OVER, second instance in BOSS
      #2 rst = 1'b0;
      #1;
      chk_rst("mid_a", a_if.state, a_if.play_en, a_if.end_en, a_if.win, a_if.boss_spawn,
              a_if.game_rst_n, a_if.score);
      chk_rst("mid_b", b_if.state, b_if.play_en, b_if.end_en, b_if.win, b_if.boss_spawn,
              b_if.game_rst_n, b_if.score);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_state", 0, 32'(a_if.state), 32'(S_IDLE));
      chk("post_rst_score", 0, 32'(b_if.score), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
